// File: rtl/trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trap_ctrl : commits machine trap state, MRET returns and pipeline redirect |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [1:0]  MODE_RESET  = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mmu_wait,
  input  logic        i_trap_en,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_code,
  input  logic [31:0] i_trap_jmp_to,
  input  logic        i_chmode_do,
  input  logic [1:0]  i_chmode_to,
  input  logic        i_ret_do,
  input  logic [11:0] i_csr_raddr,
  output logic [31:0] o_csr_rdata,
  input  logic        i_csr_wren,
  input  logic [11:0] i_csr_waddr,
  input  logic [31:0] i_csr_wdata,
  output logic [1:0]  o_trap_vec_mode,
  output logic [31:0] o_trap_vec_base,
  output logic        o_int_allow,
  output logic [1:0]  o_mode,
  output logic        o_flush,
  output logic        o_jmp_do,
  output logic [31:0] o_jmp_pc
);

  localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_mode;
  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_flush;
  logic        r_jmp_do;
  logic [31:0] r_jmp_pc;

  logic        w_idle;
  logic        w_take_trap;
  logic        w_take_ret;
  logic        w_take_chmode;
  logic        w_wr_mstatus;
  logic        w_wr_mtvec;
  logic        w_wr_mepc;
  logic        w_wr_mcause;
  logic [31:0] w_mtvec_wdata;
  logic [1:0]  w_mpp_wdata;
  logic [31:0] w_mstatus;

  assign w_idle        = (r_state == S_IDLE);
  assign w_take_trap   = w_idle && i_trap_en;
  assign w_take_ret    = w_idle && !i_trap_en && i_ret_do;
  assign w_take_chmode = w_idle && !i_trap_en && !i_ret_do && i_chmode_do;

  assign w_wr_mstatus  = i_csr_wren && (i_csr_waddr == c_ADDR_MSTATUS);
  assign w_wr_mtvec    = i_csr_wren && (i_csr_waddr == c_ADDR_MTVEC);
  assign w_wr_mepc     = i_csr_wren && (i_csr_waddr == c_ADDR_MEPC);
  assign w_wr_mcause   = i_csr_wren && (i_csr_waddr == c_ADDR_MCAUSE);

  // Reserved vector mode encodings (bit1 set) collapse to direct mode
  assign w_mtvec_wdata = {i_csr_wdata[31:2], i_csr_wdata[1] ? 2'b00 : i_csr_wdata[1:0]};
  assign w_mpp_wdata   = (i_csr_wdata[12:11] == 2'b10) ? 2'b00 : i_csr_wdata[12:11];

  assign w_mstatus = {19'd0, r_mpp, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

  always_comb begin
    o_csr_rdata = 32'd0;
    case (i_csr_raddr)
      c_ADDR_MSTATUS: o_csr_rdata = w_mstatus;
      c_ADDR_MTVEC:   o_csr_rdata = r_mtvec;
      c_ADDR_MEPC:    o_csr_rdata = r_mepc;
      c_ADDR_MCAUSE:  o_csr_rdata = r_mcause;
      default:        o_csr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mode   <= MODE_RESET;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mpp    <= 2'b00;
      r_mtvec  <= {MTVEC_RESET[31:2], 2'b00};
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
      r_flush  <= 1'b0;
      r_jmp_do <= 1'b0;
      r_jmp_pc <= 32'd0;
    end else if (!i_mmu_wait) begin
      // Trap/return state updates take precedence over software CSR writes
      if (w_wr_mtvec) r_mtvec <= w_mtvec_wdata;
      if (w_wr_mepc && !w_take_trap) r_mepc <= {i_csr_wdata[31:2], 2'b00};
      if (w_wr_mcause && !w_take_trap) r_mcause <= i_csr_wdata;
      if (w_wr_mstatus && !w_take_trap && !w_take_ret) begin
        r_mie  <= i_csr_wdata[3];
        r_mpie <= i_csr_wdata[7];
        r_mpp  <= w_mpp_wdata;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take_trap) begin
            r_mepc   <= i_trap_pc;
            r_mcause <= i_trap_code;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mpp    <= r_mode;
            r_mode   <= 2'b11;
            r_jmp_pc <= i_trap_jmp_to;
            r_flush  <= 1'b1;
            r_jmp_do <= 1'b1;
            r_state  <= S_REDIR;
          end else if (w_take_ret) begin
            r_mode   <= r_mpp;
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_mpp    <= 2'b00;
            r_jmp_pc <= r_mepc;
            r_flush  <= 1'b1;
            r_jmp_do <= 1'b1;
            r_state  <= S_REDIR;
          end else if (w_take_chmode) begin
            r_mode <= i_chmode_to;
          end
        end
        S_REDIR: begin
          r_flush  <= 1'b0;
          r_jmp_do <= 1'b0;
          r_state  <= S_BLANK;
        end
        // Privilege-stage request registers are stale here; ignore them
        S_BLANK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_trap_vec_mode = r_mtvec[1:0];
  assign o_trap_vec_base = {r_mtvec[31:2], 2'b00};
  assign o_int_allow     = r_mie;
  assign o_mode          = r_mode;
  assign o_flush         = r_flush;
  assign o_jmp_do        = r_jmp_do;
  assign o_jmp_pc        = r_jmp_pc;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trap_ctrl : directed and random checks of trap_ctrl against a model     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mmu_wait, i_trap_en, i_chmode_do, i_ret_do, i_csr_wren;
  logic [31:0] i_trap_pc, i_trap_code, i_trap_jmp_to, i_csr_wdata;
  logic [1:0]  i_chmode_to;
  logic [11:0] i_csr_raddr, i_csr_waddr;
  logic [31:0] o_csr_rdata, o_trap_vec_base, o_jmp_pc;
  logic [1:0]  o_trap_vec_mode, o_mode;
  logic        o_int_allow, o_flush, o_jmp_do;

  int n_assert = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [1:0]  m_mode, m_mpp;
  logic        m_mie, m_mpie, m_pulse;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_jmp_pc;
  int          m_busy;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_mmu_wait(i_mmu_wait),
    .i_trap_en(i_trap_en), .i_trap_pc(i_trap_pc), .i_trap_code(i_trap_code),
    .i_trap_jmp_to(i_trap_jmp_to), .i_chmode_do(i_chmode_do), .i_chmode_to(i_chmode_to),
    .i_ret_do(i_ret_do), .i_csr_raddr(i_csr_raddr), .o_csr_rdata(o_csr_rdata),
    .i_csr_wren(i_csr_wren), .i_csr_waddr(i_csr_waddr), .i_csr_wdata(i_csr_wdata),
    .o_trap_vec_mode(o_trap_vec_mode), .o_trap_vec_base(o_trap_vec_base),
    .o_int_allow(o_int_allow), .o_mode(o_mode), .o_flush(o_flush),
    .o_jmp_do(o_jmp_do), .o_jmp_pc(o_jmp_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 2'b11; m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b00;
    m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    m_pulse = 1'b0; m_jmp_pc = 32'd0; m_busy = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    logic [1:0]  o_mode_s, o_mpp_s;
    logic        o_mie_s, o_mpie_s, trap, ret, chm;
    logic [31:0] o_mepc_s;
    if (!rst_n) begin model_reset(); return; end
    if (i_mmu_wait) return;
    o_mode_s = m_mode; o_mpp_s = m_mpp; o_mie_s = m_mie; o_mpie_s = m_mpie; o_mepc_s = m_mepc;
    trap = (m_busy == 0) && i_trap_en;
    ret  = (m_busy == 0) && !i_trap_en && i_ret_do;
    chm  = (m_busy == 0) && !i_trap_en && !i_ret_do && i_chmode_do;
    if (m_busy > 0) begin m_busy--; m_pulse = 1'b0; end
    if (trap) begin
      m_mepc = i_trap_pc; m_mcause = i_trap_code;
      m_mpie = o_mie_s; m_mie = 1'b0; m_mpp = o_mode_s; m_mode = 2'b11;
      m_jmp_pc = i_trap_jmp_to; m_pulse = 1'b1; m_busy = 2;
    end else if (ret) begin
      m_mode = o_mpp_s; m_mie = o_mpie_s; m_mpie = 1'b1; m_mpp = 2'b00;
      m_jmp_pc = o_mepc_s; m_pulse = 1'b1; m_busy = 2;
    end else if (chm) begin
      m_mode = i_chmode_to;
    end
    if (i_csr_wren) begin
      if (i_csr_waddr == 12'h305)
        m_mtvec = i_csr_wdata[1] ? (i_csr_wdata & 32'hFFFF_FFFC) : i_csr_wdata;
      if (i_csr_waddr == 12'h341 && !trap) m_mepc = i_csr_wdata & 32'hFFFF_FFFC;
      if (i_csr_waddr == 12'h342 && !trap) m_mcause = i_csr_wdata;
      if (i_csr_waddr == 12'h300 && !trap && !ret) begin
        m_mie  = i_csr_wdata[3];
        m_mpie = i_csr_wdata[7];
        m_mpp  = (i_csr_wdata[12:11] == 2'b10) ? 2'b00 : i_csr_wdata[12:11];
      end
    end
  endtask

  task automatic check_all();
    chk("flush",    32'(o_flush),         32'(m_pulse));
    chk("jmp_do",   32'(o_jmp_do),        32'(m_pulse));
    chk("jmp_pc",   o_jmp_pc,             m_jmp_pc);
    chk("mode",     32'(o_mode),          32'(m_mode));
    chk("int_allow",32'(o_int_allow),     32'(m_mie));
    chk("vec_mode", 32'(o_trap_vec_mode), 32'(m_mtvec[1:0]));
    chk("vec_base", o_trap_vec_base,      m_mtvec & 32'hFFFF_FFFC);
    chk("csr_rdata",o_csr_rdata,          model_read(i_csr_raddr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_in();
    i_mmu_wait = 0; i_trap_en = 0; i_chmode_do = 0; i_ret_do = 0; i_csr_wren = 0;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      3: return 12'h342;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; clear_in();
    i_trap_pc = 0; i_trap_code = 0; i_trap_jmp_to = 0; i_chmode_to = 0;
    i_csr_raddr = 12'h305; i_csr_waddr = 0; i_csr_wdata = 0;
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_mode", 32'(o_mode), 32'h3);
    chk("rst_int_allow", 32'(o_int_allow), 32'h0);
    chk("rst_vec_base", o_trap_vec_base, 32'h0);
    chk("rst_flush", 32'(o_flush), 32'h0);
    chk("rst_mtvec_rd", o_csr_rdata, 32'h0);

    // mtvec and mstatus writes
    i_csr_wren = 1; i_csr_waddr = 12'h305; i_csr_wdata = 32'h8000_0101; tick();
    i_csr_waddr = 12'h300; i_csr_wdata = 32'h0000_0008; tick();
    i_csr_wren = 0;
    chk("wr_vec_mode", 32'(o_trap_vec_mode), 32'h1);
    chk("wr_vec_base", o_trap_vec_base, 32'h8000_0100);
    chk("wr_int_allow", 32'(o_int_allow), 32'h1);

    // Trap, with TRAP_EN held through the blank cycle
    i_trap_en = 1; i_trap_pc = 32'h0000_1234; i_trap_code = 32'h8000_0007;
    i_trap_jmp_to = 32'h8000_011C; i_csr_raddr = 12'h341;
    tick();
    chk("trap_flush", 32'(o_flush), 32'h1);
    chk("trap_jmp_pc", o_jmp_pc, 32'h8000_011C);
    chk("trap_mepc", o_csr_rdata, 32'h0000_1234);
    tick();
    chk("trap_flush_end", 32'(o_flush), 32'h0);
    tick();
    i_trap_en = 0; i_csr_raddr = 12'h300;
    tick();
    chk("trap_blank_ignored", 32'(o_jmp_do), 32'h0);
    chk("trap_mstatus", o_csr_rdata, 32'h0000_1880);
    i_csr_raddr = 12'h342; tick();
    chk("trap_mcause", o_csr_rdata, 32'h8000_0007);

    // MRET
    i_ret_do = 1; i_csr_raddr = 12'h300; tick();
    i_ret_do = 0;
    chk("ret_jmp_do", 32'(o_jmp_do), 32'h1);
    chk("ret_jmp_pc", o_jmp_pc, 32'h0000_1234);
    chk("ret_mode", 32'(o_mode), 32'h3);
    chk("ret_int_allow", 32'(o_int_allow), 32'h1);
    chk("ret_mstatus", o_csr_rdata, 32'h0000_0088);
    tick(); tick();

    // Trap + MRET + mepc write together
    i_trap_en = 1; i_ret_do = 1; i_trap_pc = 32'h0000_2000; i_trap_code = 32'h2;
    i_trap_jmp_to = 32'h8000_0100; i_csr_wren = 1; i_csr_waddr = 12'h341;
    i_csr_wdata = 32'h0000_FFFF; i_csr_raddr = 12'h341;
    tick();
    clear_in();
    chk("coll_jmp_pc", o_jmp_pc, 32'h8000_0100);
    chk("coll_mepc", o_csr_rdata, 32'h0000_2000);
    tick(); tick(); tick();
    i_csr_wren = 1; i_csr_waddr = 12'h341; i_csr_wdata = 32'h0000_1237; tick();
    i_csr_wren = 0;
    chk("mepc_align", o_csr_rdata, 32'h0000_1234);

    // Stall during redirect stretches the pulse and blocks CSR writes
    i_trap_en = 1; i_trap_pc = 32'h3000; i_trap_code = 32'h5; i_trap_jmp_to = 32'h8000_0200;
    i_csr_raddr = 12'h342; tick();
    i_trap_en = 0; i_mmu_wait = 1; i_csr_wren = 1; i_csr_waddr = 12'h342; i_csr_wdata = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_flush", 32'(o_flush), 32'h1);
    end
    clear_in(); tick();
    chk("stall_flush_end", 32'(o_flush), 32'h0);
    chk("stall_mcause", o_csr_rdata, 32'h5);
    tick(); tick();

    // Async reset during redirect
    i_trap_en = 1; tick();
    i_trap_en = 0;
    chk("pre_rst_flush", 32'(o_flush), 32'h1);
    rst_n = 1'b0; #1;
    chk("arst_flush", 32'(o_flush), 32'h0);
    chk("arst_jmp_do", 32'(o_jmp_do), 32'h0);
    chk("arst_jmp_pc", o_jmp_pc, 32'h0);
    model_reset();
    tick();
    rst_n = 1'b1; tick();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      i_trap_en     = ($urandom_range(0, 7) == 0);
      i_ret_do      = ($urandom_range(0, 5) == 0);
      i_chmode_do   = ($urandom_range(0, 4) == 0);
      i_chmode_to   = 2'($urandom);
      i_mmu_wait    = ($urandom_range(0, 9) == 0);
      i_trap_pc     = $urandom; i_trap_code = $urandom; i_trap_jmp_to = $urandom;
      i_csr_wren    = ($urandom_range(0, 2) == 0);
      i_csr_waddr   = pick_addr();
      i_csr_wdata   = $urandom;
      i_csr_raddr   = pick_addr();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
